// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared constants, state enums and command payload type for
// the host command receiver (uart_cmd_rx) and its serial core (uart_rx_core).
// Optional feature macro used by the importers: UART_CMD_TIMEOUT_EN.
package uart_cmd_pkg;

    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned TICKS_PER_BIT   = 4;
    localparam int unsigned TICK_CNT_W      = 3;
    localparam int unsigned BIT_IDX_W       = 3;
    localparam int unsigned TIMEOUT_TICKS   = 128;
    localparam int unsigned TIMEOUT_W       = $clog2(TIMEOUT_TICKS);

    localparam logic [BYTE_W-1:0] HEADER_DEFAULT  = 8'hA5;
    localparam logic [BYTE_W-1:0] OP_SET_TIMEBIN  = 8'h01;
    localparam logic [BYTE_W-1:0] OP_SET_MODE     = 8'h02;
    localparam logic [BYTE_W-1:0] OP_SEND_TIMEBIN = 8'h03;
    localparam logic [BYTE_W-1:0] TIMEBIN_RESET   = 8'd1;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    typedef enum logic [1:0] {
        P_HDR,
        P_OP,
        P_ARG,
        P_CHK
    } parser_state_t;

    typedef struct packed {
        logic [BYTE_W-1:0] op;
        logic [BYTE_W-1:0] arg;
    } cmd_t;

    // Expected checksum byte for a latched opcode/argument pair.
    function automatic logic [BYTE_W-1:0] cmd_checksum(input cmd_t c);
        return c.op ^ c.arg;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 serial receiver at 4 ticks per bit.
//   clk, rst          master clock, asynchronous active-low reset
//   i_rx_line         raw serial input, idle high
//   o_rx_byte         last received byte (registered)
//   o_rx_valid        one-cycle pulse, byte received with good stop bit
//   o_rx_error        one-cycle pulse, stop bit sampled low
//   o_rx_error_nxt_c  combinational: o_rx_error will assert next cycle
//   o_busy_nxt_c      combinational: core will be out of IDLE next cycle
//   o_tick_c          quarter-bit tick (only with UART_CMD_TIMEOUT_EN)
module uart_rx_core
    import uart_cmd_pkg::*;
#(
    parameter int unsigned CLOCK_DIVIDE = 54
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rx_line,
    output logic [BYTE_W-1:0] o_rx_byte,
    output logic              o_rx_valid,
    output logic              o_rx_error,
    output logic              o_rx_error_nxt_c,
    output logic              o_busy_nxt_c
`ifdef UART_CMD_TIMEOUT_EN
    ,
    output logic              o_tick_c
`endif
);

    localparam int unsigned DIV_W = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLOCK_DIVIDE - 1);
    localparam logic [TICK_CNT_W-1:0] HALF_BIT = TICK_CNT_W'(TICKS_PER_BIT / 2);
    localparam logic [TICK_CNT_W-1:0] FULL_BIT = TICK_CNT_W'(TICKS_PER_BIT);

    logic [2:0]              r_sync;
    logic                    r_rx;
    logic [DIV_W-1:0]        r_div;
    logic                    w_tick;
    logic                    w_reload;
    logic                    w_sample;

    rx_state_t               r_state, w_state_nxt;
    logic [TICK_CNT_W-1:0]   r_ticks, w_ticks_nxt;
    logic [BIT_IDX_W-1:0]    r_bit, w_bit_nxt;
    logic [BYTE_W-1:0]       r_shift, w_shift_nxt;
    logic [BYTE_W-1:0]       r_rx_byte, w_byte_nxt;
    logic                    r_rx_valid, w_valid_nxt;
    logic                    r_rx_error, w_error_nxt;

    // Majority-free glitch filter: only three equal samples change the level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= 3'b111;
            r_rx   <= 1'b1;
        end else begin
            r_sync <= {r_sync[1:0], i_rx_line};
            if (r_sync == 3'b111) begin
                r_rx <= 1'b1;
            end else if (r_sync == 3'b000) begin
                r_rx <= 1'b0;
            end
        end
    end

    // Quarter-bit tick divider, realigned to each detected start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= DIV_RELOAD;
        end else if (w_reload || w_tick) begin
            r_div <= DIV_RELOAD;
        end else begin
            r_div <= r_div - DIV_W'(1);
        end
    end

    assign w_tick   = (r_div == '0);
    assign w_sample = w_tick && (r_ticks == TICK_CNT_W'(1));

    // Frame state register and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= RX_IDLE;
            r_ticks    <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_rx_byte  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_error <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ticks    <= w_ticks_nxt;
            r_bit      <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_rx_byte  <= w_byte_nxt;
            r_rx_valid <= w_valid_nxt;
            r_rx_error <= w_error_nxt;
        end
    end

    // Frame sequencing: start check at half bit, then one sample per bit.
    always_comb begin
        w_state_nxt = r_state;
        w_ticks_nxt = r_ticks;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_byte_nxt  = r_rx_byte;
        w_valid_nxt = 1'b0;
        w_error_nxt = 1'b0;
        w_reload    = 1'b0;

        if (w_tick && (r_ticks != '0)) begin
            w_ticks_nxt = r_ticks - TICK_CNT_W'(1);
        end

        case (r_state)
            RX_IDLE: begin
                if (!r_rx) begin
                    w_state_nxt = RX_START;
                    w_ticks_nxt = HALF_BIT;
                    w_reload    = 1'b1;
                end
            end
            RX_START: begin
                if (w_sample) begin
                    if (r_rx) begin
                        w_state_nxt = RX_IDLE;
                    end else begin
                        w_state_nxt = RX_DATA;
                        w_ticks_nxt = FULL_BIT;
                        w_bit_nxt   = '0;
                    end
                end
            end
            RX_DATA: begin
                if (w_sample) begin
                    w_shift_nxt = {r_rx, r_shift[BYTE_W-1:1]};
                    w_ticks_nxt = FULL_BIT;
                    if (r_bit == BIT_IDX_W'(BYTE_W - 1)) begin
                        w_state_nxt = RX_STOP;
                    end else begin
                        w_bit_nxt = r_bit + BIT_IDX_W'(1);
                    end
                end
            end
            RX_STOP: begin
                if (w_sample) begin
                    if (r_rx) begin
                        w_valid_nxt = 1'b1;
                        w_byte_nxt  = r_shift;
                        w_state_nxt = RX_IDLE;
                    end else begin
                        w_error_nxt = 1'b1;
                        w_state_nxt = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                if (r_rx) begin
                    w_state_nxt = RX_IDLE;
                end
            end
            default: begin
                w_state_nxt = RX_IDLE;
            end
        endcase
    end

    assign o_rx_byte        = r_rx_byte;
    assign o_rx_valid       = r_rx_valid;
    assign o_rx_error       = r_rx_error;
    assign o_rx_error_nxt_c = w_error_nxt;
    assign o_busy_nxt_c     = (w_state_nxt != RX_IDLE);
`ifdef UART_CMD_TIMEOUT_EN
    assign o_tick_c         = w_tick;
`endif

endmodule

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: host command receiver. Assembles HEADER/op/arg/checksum packets
// from the serial line and drives the count transmitter's control inputs.
//   clk, rst         master clock, asynchronous active-low reset
//   rx_line          raw serial input, idle high
//   rx_byte/rx_valid/rx_error   byte-level receive status
//   cmd_valid/cmd_error         one-cycle packet accept / reject pulses
//   timebin_factor, two_bytes, stop_uart   control registers
//   send_timebin     one-cycle request pulse
//   busy             core mid-frame or parser mid-packet
// Optional: define UART_CMD_TIMEOUT_EN to abandon packets stalled for 128 ticks.
module uart_cmd_rx
    import uart_cmd_pkg::*;
#(
    parameter int unsigned       CLOCK_DIVIDE = 54,
    parameter logic [BYTE_W-1:0] HEADER       = HEADER_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_line,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              rx_valid,
    output logic              rx_error,
    output logic              cmd_valid,
    output logic              cmd_error,
    output logic [BYTE_W-1:0] timebin_factor,
    output logic              two_bytes,
    output logic              stop_uart,
    output logic              send_timebin,
    output logic              busy
);

    logic [BYTE_W-1:0] w_rx_byte;
    logic              w_rx_valid;
    logic              w_rx_error;
    logic              w_rx_error_nxt;
    logic              w_core_busy_nxt;
`ifdef UART_CMD_TIMEOUT_EN
    logic              w_tick;
    logic [TIMEOUT_W-1:0] r_to_cnt, w_to_nxt;
`endif

    parser_state_t     r_pstate, w_pstate_nxt;
    cmd_t              r_cmd, w_cmd_nxt;
    logic [BYTE_W-1:0] r_tbf, w_tbf_nxt;
    logic              r_two, w_two_nxt;
    logic              r_stop, w_stop_nxt;
    logic              r_cmd_valid, w_cmd_valid_nxt;
    logic              r_cmd_error, w_cmd_error_nxt;
    logic              r_send, w_send_nxt;
    logic              r_busy;

    uart_rx_core #(
        .CLOCK_DIVIDE (CLOCK_DIVIDE)
    ) u_core (
        .clk              (clk),
        .rst              (rst),
        .i_rx_line        (rx_line),
        .o_rx_byte        (w_rx_byte),
        .o_rx_valid       (w_rx_valid),
        .o_rx_error       (w_rx_error),
        .o_rx_error_nxt_c (w_rx_error_nxt),
        .o_busy_nxt_c     (w_core_busy_nxt)
`ifdef UART_CMD_TIMEOUT_EN
        ,
        .o_tick_c         (w_tick)
`endif
    );

    // Parser state and control registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pstate    <= P_HDR;
            r_cmd       <= '0;
            r_tbf       <= TIMEBIN_RESET;
            r_two       <= 1'b0;
            r_stop      <= 1'b1;
            r_cmd_valid <= 1'b0;
            r_cmd_error <= 1'b0;
            r_send      <= 1'b0;
            r_busy      <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
            r_to_cnt    <= '0;
`endif
        end else begin
            r_pstate    <= w_pstate_nxt;
            r_cmd       <= w_cmd_nxt;
            r_tbf       <= w_tbf_nxt;
            r_two       <= w_two_nxt;
            r_stop      <= w_stop_nxt;
            r_cmd_valid <= w_cmd_valid_nxt;
            r_cmd_error <= w_cmd_error_nxt;
            r_send      <= w_send_nxt;
            r_busy      <= w_core_busy_nxt || (w_pstate_nxt != P_HDR);
`ifdef UART_CMD_TIMEOUT_EN
            r_to_cnt    <= w_to_nxt;
`endif
        end
    end

    // Packet parsing and command execution.
    always_comb begin
        w_pstate_nxt    = r_pstate;
        w_cmd_nxt       = r_cmd;
        w_tbf_nxt       = r_tbf;
        w_two_nxt       = r_two;
        w_stop_nxt      = r_stop;
        w_cmd_valid_nxt = 1'b0;
        w_cmd_error_nxt = 1'b0;
        w_send_nxt      = 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
        w_to_nxt        = r_to_cnt;
`endif

        case (r_pstate)
            P_HDR: begin
                if (w_rx_valid && (w_rx_byte == HEADER)) begin
                    w_pstate_nxt = P_OP;
                end
            end
            P_OP: begin
                if (w_rx_valid) begin
                    w_cmd_nxt.op = w_rx_byte;
                    w_pstate_nxt = P_ARG;
                end
            end
            P_ARG: begin
                if (w_rx_valid) begin
                    w_cmd_nxt.arg = w_rx_byte;
                    w_pstate_nxt  = P_CHK;
                end
            end
            P_CHK: begin
                if (w_rx_valid) begin
                    w_pstate_nxt = P_HDR;
                    if (w_rx_byte != cmd_checksum(r_cmd)) begin
                        w_cmd_error_nxt = 1'b1;
                    end else begin
                        case (r_cmd.op)
                            OP_SET_TIMEBIN: begin
                                w_tbf_nxt       = r_cmd.arg;
                                w_cmd_valid_nxt = 1'b1;
                            end
                            OP_SET_MODE: begin
                                w_two_nxt       = r_cmd.arg[0];
                                w_stop_nxt      = r_cmd.arg[1];
                                w_cmd_valid_nxt = 1'b1;
                            end
                            OP_SEND_TIMEBIN: begin
                                w_send_nxt      = 1'b1;
                                w_cmd_valid_nxt = 1'b1;
                            end
                            default: begin
                                w_cmd_error_nxt = 1'b1;
                            end
                        endcase
                    end
                end
            end
            default: begin
                w_pstate_nxt = P_HDR;
            end
        endcase

`ifdef UART_CMD_TIMEOUT_EN
        // Idle-tick watchdog, restarted by every received byte.
        if ((r_pstate == P_HDR) || w_rx_valid) begin
            w_to_nxt = '0;
        end else if (w_tick) begin
            if (r_to_cnt == TIMEOUT_W'(TIMEOUT_TICKS - 1)) begin
                w_to_nxt        = '0;
                w_pstate_nxt    = P_HDR;
                w_cmd_error_nxt = 1'b1;
            end else begin
                w_to_nxt = r_to_cnt + TIMEOUT_W'(1);
            end
        end
`endif

        // Framing error aborts a partial packet; uses the core's next-cycle
        // flag so cmd_error lines up with rx_error.
        if (w_rx_error_nxt && (r_pstate != P_HDR)) begin
            w_pstate_nxt    = P_HDR;
            w_cmd_error_nxt = 1'b1;
        end
    end

    assign rx_byte        = w_rx_byte;
    assign rx_valid       = w_rx_valid;
    assign rx_error       = w_rx_error;
    assign cmd_valid      = r_cmd_valid;
    assign cmd_error      = r_cmd_error;
    assign timebin_factor = r_tbf;
    assign two_bytes      = r_two;
    assign stop_uart      = r_stop;
    assign send_timebin   = r_send;
    assign busy           = r_busy;

endmodule
